a8bit_add_pipe: RTL and testbench
=================================

A8BIT_ADD_PIPE -- requirements
Module: a8bit_add_pipe

Interface
REQ-001 Parameter SEG_W, default 8: width in bits of one carry segment.
REQ-002 Parameter SEGS, default 3: number of segments; DATA_W = SEG_W*SEGS.
REQ-003 The block SHALL have the following ports, clock and reset first:
- I_clk     in   1       single clock; all state updates on its rising edge.
- I_rst_n   in   1       asynchronous, active-low reset.
- I_ce      in   1       pipeline enable; when low, all stages hold.
- I_valid   in   1       operand qualifier.
- I_sub     in   1       0 = add, 1 = subtract.
- I_cin     in   1       carry-in (add) or borrow-in (subtract).
- I_adder0  in   DATA_W  operand A.
- I_adder1  in   DATA_W  operand B.
- O_sum     out  DATA_W  result.
- O_cout    out  1       carry-out of the top segment.
- O_ovf     out  1       two's-complement signed overflow.
- O_valid   out  1       result qualifier.

Function
REQ-004 Function: The block SHALL compute A + B' + c:
- add: B' = B, c = I_cin.
- subtract: B' = ~B, c = ~I_cin, giving A - B - I_cin.
REQ-005 Arithmetic: The block SHALL use modulo 2^DATA_W arithmetic.
- O_cout = raw carry out of bit DATA_W-1.
- In subtract, O_cout = 1 means no borrow.
REQ-006 Overflow: O_ovf SHALL be 1 iff A[MSB] == B'[MSB] and O_sum[MSB] != A[MSB].
REQ-007 Pipeline structure: The block SHALL be a carry-propagating pipeline.
- Edge 0 (I_ce=1): captures operands, I_sub, c and I_valid into stage-0 registers.
- Edge j+1: computes segment j using the registered carry from segment j-1 (segment 0 uses c).
- Per-segment adders SHALL be SEG_W+1 bits; no adder SHALL span more than one segment.
REQ-008 Skew alignment: Unused upper operand segments SHALL be delayed, and completed lower sums SHALL be delayed, so that all segments of one operation reach the output registers together.
REQ-009 Latency: The latency SHALL be SEGS+1 enabled edges from capture to O_sum/O_cout/O_ovf/O_valid, which are all registered outputs.
REQ-010 Throughput: The block SHALL accept one operation per enabled cycle with no bubbles, and results SHALL exit in input order.
REQ-011 Valid travel: I_valid SHALL travel with its operands in a SEGS+1-deep valid shift register.
- O_valid = 1 exactly when the output registers hold a result captured with I_valid=1.
REQ-012 Invalid slots: The datapath MAY update on invalid slots; O_sum/O_cout/O_ovf are don't-care while O_valid=0.
REQ-013 Stall: When I_ce=0, every pipeline register, including valid bits and outputs, SHALL hold its value.
- I_valid and operands are ignored that cycle.
- An I_ce=0 cycle does not count toward latency.
REQ-014 Degenerate SEGS=1: The block SHALL degenerate to one registered input stage plus one adder stage, latency 2.
REQ-015 Default-parameter behaviour: With the default parameters, behaviour SHALL be bit-identical to the existing 24-bit 3-segment adder for add, I_cin=0, with one extra cycle of latency.

Reset
REQ-016 Asynchronous reset: While I_rst_n=0, all registers SHALL be cleared asynchronously: O_sum=0, O_cout=0, O_ovf=0, O_valid=0.
REQ-017 Reset mid-operation: A reset during operation SHALL discard all in-flight operations; no result captured before the reset SHALL ever assert O_valid.
REQ-018 Reset release: After I_rst_n rises, the first capture SHALL occur on the first rising edge with I_ce=1.

Verification
REQ-019 Directed scenarios (SEG_W=8, SEGS=3) SHALL be covered:
- Add carry ripple: A=0xFFFFFF, B=0x000001, sub=0, cin=0 -> 4 enabled edges later O_sum=0x000000, O_cout=1, O_ovf=0, O_valid=1 for 1 cycle.
- Subtract borrow: A=0x000000, B=0x000001, sub=1, cin=0 -> O_sum=0xFFFFFF, O_cout=0, O_ovf=0.
- Signed overflow: A=0x7FFFFF, B=0x000001, add -> O_sum=0x800000, O_ovf=1, O_cout=0.
  - A=0x800000, B=0x000001, sub -> O_sum=0x7FFFFF, O_ovf=1.
- Streaming: 100 back-to-back random valid operations with random I_valid gaps and I_cin/I_sub -> every result matches the reference model in order, each exactly 4 enabled edges after capture.
- Stall: I_ce=0 for 2 cycles with 3 operations in flight -> outputs frozen during the stall, all 3 results emerge in order, latency extended by exactly 2 cycles.
- Reset mid-flight: I_rst_n pulsed low with 3 operations in flight -> O_valid=0 immediately, outputs 0, no stale O_valid after release.
  - Repeat the streaming scenario with SEGS=1 and SEG_W=16.

Source files
------------

// File: rtl/a8bit_add_pipe.sv
// Segmented carry-propagating adder/subtractor pipeline: one SEG_W-bit segment
// per stage, with operand/sum skew registers so a whole result exits together.
module a8bit_add_pipe #(
  parameter int SEG_W = 8,
  parameter int SEGS  = 3,
  localparam int DATA_W = SEG_W * SEGS
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_ce,
  input  logic              I_valid,
  input  logic              I_sub,
  input  logic              I_cin,
  input  logic [DATA_W-1:0] I_adder0,
  input  logic [DATA_W-1:0] I_adder1,
  output logic [DATA_W-1:0] O_sum,
  output logic              O_cout,
  output logic              O_ovf,
  output logic              O_valid
);

  // Handshake: I_valid qualifies the operands on any edge with I_ce=1; there is
  // no back-pressure. O_valid marks the output registers as holding a real result.

  // Stage k holds the operands waiting for segment k and the carry into it.
  logic [DATA_W-1:0] r_a [SEGS];
  logic [DATA_W-1:0] r_b [SEGS];
  logic [DATA_W-1:0] r_s [1:SEGS];
  logic              r_c [SEGS+1];
  logic              r_v [SEGS+1];
  logic              r_ovf;
  logic [SEG_W:0]    w_add [SEGS];
  logic              w_ovf;

  always_comb begin
    for (int k = 0; k < SEGS; k++) begin
      w_add[k] = {1'b0, r_a[k][k*SEG_W +: SEG_W]}
               + {1'b0, r_b[k][k*SEG_W +: SEG_W]}
               + {{SEG_W{1'b0}}, r_c[k]};
    end
    // Signs agree going in but the result sign differs.
    w_ovf = (r_a[SEGS-1][DATA_W-1] == r_b[SEGS-1][DATA_W-1])
         && (w_add[SEGS-1][SEG_W-1] != r_a[SEGS-1][DATA_W-1]);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int k = 0; k < SEGS; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      for (int k = 1; k <= SEGS; k++) begin
        r_s[k] <= '0;
      end
      for (int k = 0; k <= SEGS; k++) begin
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (I_ce) begin
      r_a[0] <= I_adder0;
      r_b[0] <= I_sub ? ~I_adder1 : I_adder1;
      r_c[0] <= I_sub ? ~I_cin : I_cin;
      r_v[0] <= I_valid;
      for (int k = 0; k < SEGS - 1; k++) begin
        r_a[k+1] <= r_a[k];
        r_b[k+1] <= r_b[k];
      end
      r_s[1] <= DATA_W'(w_add[0][SEG_W-1:0]);
      for (int k = 1; k < SEGS; k++) begin
        r_s[k+1]                   <= r_s[k];
        r_s[k+1][k*SEG_W +: SEG_W] <= w_add[k][SEG_W-1:0];
      end
      for (int k = 0; k < SEGS; k++) begin
        r_c[k+1] <= w_add[k][SEG_W];
        r_v[k+1] <= r_v[k];
      end
      r_ovf <= w_ovf;
    end
  end

  assign O_sum   = r_s[SEGS];
  assign O_cout  = r_c[SEGS];
  assign O_ovf   = r_ovf;
  assign O_valid = r_v[SEGS];

endmodule

// File: tb/tb_a8bit_add_pipe.sv
// Directed and streaming checks of the segmented adder pipeline, default
// 3x8 configuration plus a 1x16 instance.
module tb_a8bit_add_pipe;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        valid, sub, cin;
  logic [23:0] a0, a1, sum;
  logic        cout, ovf, ovalid;
  logic        valid1, sub1, cin1;
  logic [15:0] x0, x1, sum1;
  logic        cout1, ovf1, ovalid1;

  int checks   = 0;
  int failures = 0;

  logic [26:0] exp_q[$];
  logic [18:0] exp1_q[$];

  a8bit_add_pipe #(.SEG_W(8), .SEGS(3)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_ce(ce), .I_valid(valid), .I_sub(sub),
    .I_cin(cin), .I_adder0(a0), .I_adder1(a1), .O_sum(sum), .O_cout(cout),
    .O_ovf(ovf), .O_valid(ovalid)
  );

  a8bit_add_pipe #(.SEG_W(16), .SEGS(1)) dut1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_ce(ce), .I_valid(valid1), .I_sub(sub1),
    .I_cin(cin1), .I_adder0(x0), .I_adder1(x1), .O_sum(sum1), .O_cout(cout1),
    .O_ovf(ovf1), .O_valid(ovalid1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {ovf, cout, sum}.
  function automatic logic [25:0] model24(input logic [23:0] a, input logic [23:0] b,
                                          input logic s, input logic c);
    logic [23:0] bb;
    logic [24:0] r;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {24'd0, (s ? ~c : c)};
    return {(a[23] == bb[23]) && (r[23] != a[23]), r};
  endfunction

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic c);
    logic [15:0] bb;
    logic [16:0] r;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? ~c : c)};
    return {(a[15] == bb[15]) && (r[15] != a[15]), r};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1;
    valid = 1'b1; sub = 1'b0; cin = 1'b1; a0 = 24'h123456; a1 = 24'h654321;
    valid1 = 1'b1; sub1 = 1'b0; cin1 = 1'b1; x0 = 16'h1234; x1 = 16'h4321;
    step(); step();
    checks++;
    if ({ovalid, ovf, cout, sum} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", {ovalid, ovf, cout, sum}, 27'd0);
    end
    checks++;
    if ({ovalid1, ovf1, cout1, sum1} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs_seg1: got %h expected %h", {ovalid1, ovf1, cout1, sum1}, 19'd0);
    end
    @(negedge clk);
    valid = 1'b0; valid1 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [23:0] ta [6] = '{24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h800000, 24'h123456, 24'h000010};
    logic [23:0] tb [6] = '{24'h000001, 24'h000001, 24'h000001, 24'h000001, 24'h654321, 24'h000005};
    logic        ts [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    // {ovf, cout, sum} worked out by hand
    logic [25:0] te [6] = '{{2'b01, 24'h000000}, {2'b00, 24'hFFFFFF}, {2'b10, 24'h800000},
                            {2'b11, 24'h7FFFFF}, {2'b00, 24'h777778}, {2'b01, 24'h00000A}};
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1; a0 = ta[i]; a1 = tb[i]; sub = ts[i]; cin = tc[i];
      step();
      valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (ovalid !== 1'b0) begin
          failures++;
          $display("FAIL directed%0d_early_valid edge%0d: got %b expected 0", i, j, ovalid);
        end
        step();
      end
      checks++;
      if ({ovalid, ovf, cout, sum} !== {1'b1, te[i]}) begin
        failures++;
        $display("FAIL directed%0d_result: got %h expected %h", i, {ovalid, ovf, cout, sum}, {1'b1, te[i]});
      end
      step();
      checks++;
      if (ovalid !== 1'b0) begin
        failures++;
        $display("FAIL directed%0d_valid_pulse: got %b expected 0", i, ovalid);
      end
    end
  endtask

  task automatic test_stall();
    valid = 1'b1; sub = 1'b0; cin = 1'b0; a0 = 24'h000100; a1 = 24'h000200;
    step();
    a0 = 24'h00FF00; a1 = 24'h000100;
    step();
    sub = 1'b1; a0 = 24'h000005; a1 = 24'h000003;
    step();
    valid = 1'b0; sub = 1'b0;
    step();
    checks++;
    if ({ovalid, ovf, cout, sum} !== {3'b100, 24'h000300}) begin
      failures++;
      $display("FAIL stall_op1: got %h expected %h", {ovalid, ovf, cout, sum}, {3'b100, 24'h000300});
    end
    ce = 1'b0; valid = 1'b1; a0 = 24'hABCDEF; a1 = 24'h123456;
    for (int j = 0; j < 2; j++) begin
      step();
      checks++;
      if ({ovalid, ovf, cout, sum} !== {3'b100, 24'h000300}) begin
        failures++;
        $display("FAIL stall_frozen cycle%0d: got %h expected %h", j, {ovalid, ovf, cout, sum}, {3'b100, 24'h000300});
      end
    end
    ce = 1'b1; valid = 1'b0;
    step();
    checks++;
    if ({ovalid, ovf, cout, sum} !== {3'b100, 24'h010000}) begin
      failures++;
      $display("FAIL stall_op2: got %h expected %h", {ovalid, ovf, cout, sum}, {3'b100, 24'h010000});
    end
    step();
    checks++;
    if ({ovalid, ovf, cout, sum} !== {3'b101, 24'h000002}) begin
      failures++;
      $display("FAIL stall_op3: got %h expected %h", {ovalid, ovf, cout, sum}, {3'b101, 24'h000002});
    end
    step();
    checks++;
    if (ovalid !== 1'b0) begin
      failures++;
      $display("FAIL stall_ignored_input: got %b expected 0", ovalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] e;
    int issued = 0;
    int drain  = 0;
    exp_q.delete();
    while (issued < 100 || drain < 4) begin
      a0 = 24'($urandom); a1 = 24'($urandom);
      sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      if (issued < 100 && $urandom_range(0, 3) != 0) begin
        valid = 1'b1; issued++;
        e = {1'b1, model24(a0, a1, sub, cin)};
      end else begin
        valid = 1'b0;
        if (issued == 100) drain++;
        e = '0;
      end
      exp_q.push_back(e);
      step();
      if (exp_q.size() == 4) begin
        e = exp_q.pop_front();
        checks++;
        if (ovalid !== e[26] || (e[26] && {ovf, cout, sum} !== e[25:0])) begin
          failures++;
          $display("FAIL stream: got %h expected %h", {ovalid, ovf, cout, sum}, e);
        end
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_stream_seg1();
    logic [18:0] e;
    int issued = 0;
    int drain  = 0;
    exp1_q.delete();
    while (issued < 100 || drain < 2) begin
      x0 = 16'($urandom); x1 = 16'($urandom);
      sub1 = 1'($urandom_range(0, 1)); cin1 = 1'($urandom_range(0, 1));
      if (issued < 100 && $urandom_range(0, 3) != 0) begin
        valid1 = 1'b1; issued++;
        e = {1'b1, model16(x0, x1, sub1, cin1)};
      end else begin
        valid1 = 1'b0;
        if (issued == 100) drain++;
        e = '0;
      end
      exp1_q.push_back(e);
      step();
      if (exp1_q.size() == 2) begin
        e = exp1_q.pop_front();
        checks++;
        if (ovalid1 !== e[18] || (e[18] && {ovf1, cout1, sum1} !== e[17:0])) begin
          failures++;
          $display("FAIL stream_seg1: got %h expected %h", {ovalid1, ovf1, cout1, sum1}, e);
        end
      end
    end
    valid1 = 1'b0;
  endtask

  task automatic test_reset_mid_flight();
    valid = 1'b1; sub = 1'b0; cin = 1'b0; a0 = 24'h111111; a1 = 24'h222222;
    step();
    a0 = 24'h010101; a1 = 24'h020202;
    step();
    a0 = 24'h0F0F0F; a1 = 24'h010101;
    step();
    valid = 1'b0;
    step();
    checks++;
    if ({ovalid, ovf, cout, sum} !== {3'b100, 24'h333333}) begin
      failures++;
      $display("FAIL pre_reset_result: got %h expected %h", {ovalid, ovf, cout, sum}, {3'b100, 24'h333333});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ovalid, ovf, cout, sum} !== 27'd0) begin
      failures++;
      $display("FAIL async_reset_clear: got %h expected %h", {ovalid, ovf, cout, sum}, 27'd0);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1; a0 = 24'h000001; a1 = 24'h000002;
    step();
    valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (ovalid !== 1'b0) begin
        failures++;
        $display("FAIL stale_valid_after_reset edge%0d: got %b expected 0", j, ovalid);
      end
      step();
    end
    checks++;
    if ({ovalid, ovf, cout, sum} !== {3'b100, 24'h000003}) begin
      failures++;
      $display("FAIL first_capture_after_release: got %h expected %h", {ovalid, ovf, cout, sum}, {3'b100, 24'h000003});
    end
    for (int j = 0; j < 4; j++) begin
      step();
      checks++;
      if (ovalid !== 1'b0) begin
        failures++;
        $display("FAIL stale_valid_tail step%0d: got %b expected 0", j, ovalid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_stream_seg1();
    test_reset_mid_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
